lot_gate_controller: RTL and testbench

Admission controller for the parking-lot occupancy datapath. Sits between the enter/exit pulse decoder and the occupancy count register. It keeps a shadow occupancy and admits or rejects cars against a fixed capacity. It issues single-cycle inc/dec commands to the count register, sequences a timed gate-open state machine, and raises sticky reject/underflow flags for the display and status logic.

---
 rtl/lot_gate_controller.sv | 122 ++++++++++++
 tb/tb_lot_gate_controller.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/lot_gate_controller.sv
// Parking-lot admission controller: shadow occupancy, inc/dec commands to the
// count register, timed gate-open FSM and sticky reject/underflow status.
module lot_gate_controller #(
  parameter int W           = 16,
  parameter int CAPACITY    = 100,
  parameter int GATE_CYCLES = 100_000_000,
  parameter int RCW         = 8
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_car_enter,
  input  logic           i_car_exit,
  input  logic           i_clear_err,
  output logic           o_inc,
  output logic           o_dec,
  output logic [W-1:0]   o_occ,
  output logic           o_full,
  output logic           o_gate_open,
  output logic           o_err_reject,
  output logic           o_err_underflow,
  output logic [RCW-1:0] o_reject_cnt
);

  localparam int            TW     = $clog2(GATE_CYCLES);
  localparam logic [W-1:0]  CAP    = W'(CAPACITY);
  localparam logic [TW-1:0] T_LOAD = TW'(GATE_CYCLES - 1);

  typedef enum logic {CLOSED, OPEN} state_t;

  typedef struct packed {
    logic admit;
    logic reject;
    logic leave;
    logic uflow;
    logic pair;
  } evt_t;

  state_t        state;
  logic [TW-1:0] timer;
  evt_t          ev;
  logic          gate_ev;
  logic [W-1:0]  occ_nxt;

  always_comb begin
    ev = '0;
    case ({i_car_enter, i_car_exit})
      2'b10:   if (o_occ < CAP) ev.admit = 1'b1; else ev.reject = 1'b1;
      2'b01:   if (o_occ != '0) ev.leave = 1'b1; else ev.uflow  = 1'b1;
      2'b11:   ev.pair = 1'b1;
      default: ;
    endcase
  end

  assign gate_ev = ev.admit | ev.leave | ev.pair;

  always_comb begin
    occ_nxt = o_occ;
    if (ev.admit)      occ_nxt = o_occ + 1'b1;
    else if (ev.leave) occ_nxt = o_occ - 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_inc           <= 1'b0;
      o_dec           <= 1'b0;
      o_occ           <= '0;
      o_full          <= 1'b0;
      state           <= CLOSED;
      timer           <= '0;
      o_gate_open     <= 1'b0;
      o_err_reject    <= 1'b0;
      o_err_underflow <= 1'b0;
      o_reject_cnt    <= '0;
    end else begin
      o_inc  <= ev.admit;
      o_dec  <= ev.leave;
      o_occ  <= occ_nxt;
      o_full <= (occ_nxt == CAP);

      // Timer counts GATE_CYCLES-1 down to 0 inclusive, so the gate holds
      // for exactly GATE_CYCLES cycles after the last gate event.
      case (state)
        CLOSED: begin
          if (gate_ev) begin
            state       <= OPEN;
            timer       <= T_LOAD;
            o_gate_open <= 1'b1;
          end
        end
        OPEN: begin
          if (gate_ev) begin
            timer       <= T_LOAD;
          end else if (timer == '0) begin
            state       <= CLOSED;
            o_gate_open <= 1'b0;
          end else begin
            timer       <= timer - 1'b1;
          end
        end
        default: begin
          state       <= CLOSED;
          timer       <= '0;
          o_gate_open <= 1'b0;
        end
      endcase

      // Clear wins over a same-cycle reject/underflow.
      if (i_clear_err) begin
        o_err_reject    <= 1'b0;
        o_err_underflow <= 1'b0;
        o_reject_cnt    <= '0;
      end else begin
        if (ev.reject) begin
          o_err_reject <= 1'b1;
          if (o_reject_cnt != '1) o_reject_cnt <= o_reject_cnt + 1'b1;
        end
        if (ev.uflow) o_err_underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lot_gate_controller.sv
// Scoreboard bench for lot_gate_controller (CAPACITY=3, GATE_CYCLES=4, RCW=4).
module tb_lot_gate_controller;

  localparam int W = 16;
  localparam int RCW = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           enter = 1'b0, exit_ = 1'b0, clr = 1'b0;
  logic           inc, dec, full, gate, rej, uf;
  logic [W-1:0]   occ;
  logic [RCW-1:0] rcnt;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    int             at;
    logic           gate;
    logic [W-1:0]   occ;
    logic           full;
    logic           rej;
    logic           uf;
    logic [RCW-1:0] cnt;
  } stat_t;

  typedef struct {
    logic         is_inc;
    logic [W-1:0] occ;
    logic         full;
  } cmd_t;

  stat_t stat_q[$];
  cmd_t  cmd_q[$];

  lot_gate_controller #(.W(W), .CAPACITY(3), .GATE_CYCLES(4), .RCW(RCW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_car_enter(enter), .i_car_exit(exit_),
    .i_clear_err(clr), .o_inc(inc), .o_dec(dec), .o_occ(occ), .o_full(full),
    .o_gate_open(gate), .o_err_reject(rej), .o_err_underflow(uf),
    .o_reject_cnt(rcnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: commands are popped whenever the DUT issues one; status
  // snapshots are compared on the cycle they were scheduled for.
  always @(negedge clk) begin
    if (rst_n && (inc || dec)) begin
      checks++;
      if (cmd_q.size() == 0) begin
        failures++;
        $display("FAIL cmd_spurious cyc=%0d got inc=%0b dec=%0b occ=%0d, expected no command",
                 cyc, inc, dec, occ);
      end else begin
        cmd_t c;
        c = cmd_q.pop_front();
        if (inc !== c.is_inc || dec !== !c.is_inc || occ !== c.occ || full !== c.full) begin
          failures++;
          $display("FAIL cmd cyc=%0d got inc=%0b dec=%0b occ=%0d full=%0b, expected inc=%0b dec=%0b occ=%0d full=%0b",
                   cyc, inc, dec, occ, full, c.is_inc, !c.is_inc, c.occ, c.full);
        end
      end
    end
    while (stat_q.size() > 0 && stat_q[0].at <= cyc) begin
      stat_t s;
      s = stat_q.pop_front();
      checks++;
      if (s.at != cyc) begin
        failures++;
        $display("FAIL stat_stale cyc=%0d expected at=%0d", cyc, s.at);
      end else if (gate !== s.gate || occ !== s.occ || full !== s.full ||
                   rej !== s.rej || uf !== s.uf || rcnt !== s.cnt) begin
        failures++;
        $display("FAIL stat cyc=%0d got gate=%0b occ=%0d full=%0b rej=%0b uf=%0b cnt=%0d, expected gate=%0b occ=%0d full=%0b rej=%0b uf=%0b cnt=%0d",
                 cyc, gate, occ, full, rej, uf, rcnt, s.gate, s.occ, s.full, s.rej, s.uf, s.cnt);
      end
    end
  end

  // Asynchronous reset must clear the gate and occupancy before any clock edge.
  always @(negedge rst_n) begin
    #1;
    checks++;
    if (gate !== 1'b0 || occ !== '0 || inc !== 1'b0 || dec !== 1'b0 || full !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got gate=%0b occ=%0d inc=%0b dec=%0b full=%0b, expected all 0",
               gate, occ, inc, dec, full);
    end
  end

  task automatic step(input logic en, input logic ex, input logic cl);
    @(posedge clk); #1;
    enter = en; exit_ = ex; clr = cl;
  endtask

  // Expected state visible after the inputs of the latest step are taken.
  task automatic chk(input logic g, input int o, input logic f,
                     input logic r, input logic u, input int n);
    stat_t s;
    s.at = cyc + 1; s.gate = g; s.occ = W'(o); s.full = f;
    s.rej = r; s.uf = u; s.cnt = RCW'(n);
    stat_q.push_back(s);
  endtask

  task automatic exp_cmd(input logic is_inc, input int o, input logic f);
    cmd_t c;
    c.is_inc = is_inc; c.occ = W'(o); c.full = f;
    cmd_q.push_back(c);
  endtask

  // Gate stays open for 3 more idle cycles, then closes.
  task automatic drain(input int o, input logic f);
    for (int i = 0; i < 3; i++) begin step(0, 0, 0); chk(1, o, f, 0, 0, 0); end
    step(0, 0, 0); chk(0, o, f, 0, 0, 0);
  endtask

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    step(0, 0, 0); chk(0, 0, 0, 0, 0, 0);
    step(0, 0, 0); chk(0, 0, 0, 0, 0, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    step(0, 0, 0); chk(0, 0, 0, 0, 0, 0);

    // 1: three admitted enters, two cycles apart
    step(1, 0, 0); exp_cmd(1, 1, 0); chk(1, 1, 0, 0, 0, 0);
    step(0, 0, 0); chk(1, 1, 0, 0, 0, 0);
    step(1, 0, 0); exp_cmd(1, 2, 0); chk(1, 2, 0, 0, 0, 0);
    step(0, 0, 0); chk(1, 2, 0, 0, 0, 0);
    step(1, 0, 0); exp_cmd(1, 3, 1); chk(1, 3, 1, 0, 0, 0);
    drain(3, 1);

    // 2: rejects at full, counter saturates at 15, then clear
    for (int i = 0; i < 20; i++) begin
      step(1, 0, 0); chk(0, 3, 1, 1, 0, (i + 1 > 15) ? 15 : i + 1);
    end
    step(0, 0, 0); chk(0, 3, 1, 1, 0, 15);
    step(0, 0, 1); chk(0, 3, 1, 0, 0, 0);
    step(1, 0, 1); chk(0, 3, 1, 0, 0, 0);
    step(0, 0, 0); chk(0, 3, 1, 0, 0, 0);

    // back to empty
    step(0, 1, 0); exp_cmd(0, 2, 0); chk(1, 2, 0, 0, 0, 0);
    step(0, 1, 0); exp_cmd(0, 1, 0); chk(1, 1, 0, 0, 0, 0);
    step(0, 1, 0); exp_cmd(0, 0, 0); chk(1, 0, 0, 0, 0, 0);
    drain(0, 0);

    // 3: underflow exit
    step(0, 1, 0); chk(0, 0, 0, 0, 1, 0);
    step(0, 0, 0); chk(0, 0, 0, 0, 1, 0);
    step(0, 0, 1); chk(0, 0, 0, 0, 0, 0);

    // 4: simultaneous enter+exit at 0, 2 and 3
    step(1, 1, 0); chk(1, 0, 0, 0, 0, 0);
    drain(0, 0);
    step(1, 0, 0); exp_cmd(1, 1, 0); chk(1, 1, 0, 0, 0, 0);
    step(1, 0, 0); exp_cmd(1, 2, 0); chk(1, 2, 0, 0, 0, 0);
    drain(2, 0);
    step(1, 1, 0); chk(1, 2, 0, 0, 0, 0);
    drain(2, 0);
    step(1, 0, 0); exp_cmd(1, 3, 1); chk(1, 3, 1, 0, 0, 0);
    drain(3, 1);
    step(1, 1, 0); chk(1, 3, 1, 0, 0, 0);
    drain(3, 1);

    // 5: timer reload: second enter 3 cycles after the first
    step(0, 1, 0); exp_cmd(0, 2, 0); chk(1, 2, 0, 0, 0, 0);
    step(0, 1, 0); exp_cmd(0, 1, 0); chk(1, 1, 0, 0, 0, 0);
    drain(1, 0);
    step(1, 0, 0); exp_cmd(1, 2, 0); chk(1, 2, 0, 0, 0, 0);
    step(0, 0, 0); chk(1, 2, 0, 0, 0, 0);
    step(0, 0, 0); chk(1, 2, 0, 0, 0, 0);
    step(1, 0, 0); exp_cmd(1, 3, 1); chk(1, 3, 1, 0, 0, 0);
    drain(3, 1);
    step(0, 1, 0); exp_cmd(0, 2, 0); chk(1, 2, 0, 0, 0, 0);
    drain(2, 0);

    // 6: async reset mid-OPEN at occupancy 2
    step(1, 1, 0); chk(1, 2, 0, 0, 0, 0);
    step(0, 0, 0); chk(1, 2, 0, 0, 0, 0);
    @(posedge clk); @(negedge clk); #2;
    rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin step(0, 0, 0); chk(0, 0, 0, 0, 0, 0); end

    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    checks++;
    if (cmd_q.size() != 0 || stat_q.size() != 0) begin
      failures++;
      $display("FAIL queues_drained got cmd_q=%0d stat_q=%0d, expected 0 and 0",
               cmd_q.size(), stat_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
